// File: rtl/gbuff_port_arbiter_if.sv
// Host-side command/response bundle for gbuff_port_arbiter.
//   master : the CFU command path (drives requests, receives completions)
//   slave  : the arbiter (accepts requests, returns completions)
// Signals:
//   host_req_valid/ready   request handshake
//   host_req_we            1=write, 0=read
//   host_req_addr          16-bit word index
//   host_req_wdata         write data
//   host_rsp_valid         one-cycle completion pulse
//   host_rsp_rdata         registered read data, held until the next read completes
//   host_rsp_err           qualifies host_rsp_valid: address out of range
interface gbuff_port_arbiter_if #(
    parameter int DATA_BITS = 32
);
    logic                 host_req_valid;
    logic                 host_req_ready;
    logic                 host_req_we;
    logic [15:0]          host_req_addr;
    logic [DATA_BITS-1:0] host_req_wdata;
    logic                 host_rsp_valid;
    logic [DATA_BITS-1:0] host_rsp_rdata;
    logic                 host_rsp_err;

    modport master (
        output host_req_valid, host_req_we, host_req_addr, host_req_wdata,
        input  host_req_ready, host_rsp_valid, host_rsp_rdata, host_rsp_err
    );

    modport slave (
        input  host_req_valid, host_req_we, host_req_addr, host_req_wdata,
        output host_req_ready, host_rsp_valid, host_rsp_rdata, host_rsp_err
    );
endinterface

// File: rtl/gbuff_port_arbiter.sv
// Shares one global-buffer BRAM port between host single-word accesses and
// the TPU datapath, which takes exclusive ownership for a whole matmul.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   host            host command/response bundle (slave side)
//   tpu_req         TPU ownership request (level)
//   tpu_grant       TPU owns the BRAM port
//   tpu_wr_en/tpu_index/tpu_data_in   TPU-driven BRAM access while granted
//   ram_en/ram_wr_en/ram_index/ram_data_in   BRAM port
//   ram_data_out    BRAM read data, one cycle after the index edge
//
// state   | meaning
// IDLE    | port unused; arbitrate host vs TPU
// H_ISSUE | host access presented to BRAM (or rejected if out of range)
// H_WAIT  | host read data returning from BRAM, captured at end of cycle
// TPU     | TPU drives the BRAM port directly
module gbuff_port_arbiter #(
    parameter int ADDR_BITS = 12,
    parameter int DATA_BITS = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    gbuff_port_arbiter_if.slave  host,
    input  logic                 tpu_req,
    output logic                 tpu_grant,
    input  logic                 tpu_wr_en,
    input  logic [15:0]          tpu_index,
    input  logic [DATA_BITS-1:0] tpu_data_in,
    output logic                 ram_en,
    output logic                 ram_wr_en,
    output logic [15:0]          ram_index,
    output logic [DATA_BITS-1:0] ram_data_in,
    input  logic [DATA_BITS-1:0] ram_data_out
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        H_ISSUE = 2'd1,
        H_WAIT  = 2'd2,
        TPU     = 2'd3
    } state_t;

    state_t               state, state_nxt;
    logic                 host_first, host_first_nxt;
    logic                 we_q;
    logic [15:0]          addr_q;
    logic [DATA_BITS-1:0] wdata_q;
    logic                 rsp_valid_q;
    logic                 rsp_err_q;
    logic [DATA_BITS-1:0] rdata_q;

    logic                 ready_c;
    logic                 accept;
    logic                 rsp_set;
    logic                 err_set;
    logic                 capture;
    logic [15:0]          addr_hi;
    logic                 addr_bad;

    assign addr_hi  = addr_q >> ADDR_BITS;
    assign addr_bad = |addr_hi;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            host_first  <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state       <= state_nxt;
            host_first  <= host_first_nxt;
            rsp_valid_q <= rsp_set;
            rsp_err_q   <= err_set;
            if (accept) begin
                we_q    <= host.host_req_we;
                addr_q  <= host.host_req_addr;
                wdata_q <= host.host_req_wdata;
            end
            if (capture) begin
                rdata_q <= ram_data_out;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        host_first_nxt = host_first;
        ready_c        = 1'b0;
        accept         = 1'b0;
        rsp_set        = 1'b0;
        err_set        = 1'b0;
        capture        = 1'b0;
        tpu_grant      = 1'b0;
        ram_en         = 1'b0;
        ram_wr_en      = 1'b0;
        ram_index      = '0;
        ram_data_in    = '0;
        case (state)
            IDLE: begin
                ready_c = !tpu_req || host_first;
                if (host.host_req_valid && ready_c) begin
                    accept         = 1'b1;
                    host_first_nxt = 1'b0;
                    state_nxt      = H_ISSUE;
                end else if (tpu_req) begin
                    state_nxt = TPU;
                end
            end
            H_ISSUE: begin
                if (!addr_bad) begin
                    ram_en      = 1'b1;
                    ram_wr_en   = we_q;
                    ram_index   = addr_q;
                    ram_data_in = wdata_q;
                end
                if (we_q || addr_bad) begin
                    rsp_set   = 1'b1;
                    err_set   = addr_bad;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = H_WAIT;
                end
            end
            H_WAIT: begin
                // Hold the index so the BRAM output stays on the requested word.
                ram_en    = 1'b1;
                ram_index = addr_q;
                capture   = 1'b1;
                rsp_set   = 1'b1;
                state_nxt = IDLE;
            end
            TPU: begin
                tpu_grant   = 1'b1;
                ram_en      = 1'b1;
                ram_wr_en   = tpu_wr_en;
                ram_index   = tpu_index;
                ram_data_in = tpu_data_in;
                if (!tpu_req) begin
                    state_nxt = IDLE;
                    // A host left waiting through a TPU tenure gets the next slot.
                    if (host.host_req_valid) begin
                        host_first_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Ready is masked while reset is held so no request looks accepted then.
    assign host.host_req_ready = ready_c && !reset;
    assign host.host_rsp_valid = rsp_valid_q;
    assign host.host_rsp_err   = rsp_err_q;
    assign host.host_rsp_rdata = rdata_q;

endmodule
